// File: rtl/render_frame_scheduler.sv
// Raster-order sequencer for three_dim_renderer feeding a ready/valid framebuffer write port.
// First write RENDER_LATENCY+1 cycles after first issue; issue is credit-limited so the skid FIFO never overflows.
module render_frame_scheduler #(
  parameter  int WIDTH          = 4,
  parameter  int HEIGHT         = 2,
  parameter  int RENDER_LATENCY = 1,
  localparam int FIFO_DEPTH     = RENDER_LATENCY + 2,
  localparam int AW             = (WIDTH * HEIGHT > 1) ? $clog2(WIDTH * HEIGHT) : 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start_in,
  output logic [10:0]   x_out,
  output logic [9:0]    y_out,
  input  logic [4:0]    r_in,
  input  logic [5:0]    g_in,
  input  logic [4:0]    b_in,
  output logic [AW-1:0] fb_addr_out,
  output logic [15:0]   fb_data_out,
  output logic          fb_we_out,
  input  logic          fb_ready_in,
  output logic          busy_out,
  output logic          done_out,
  output logic [15:0]   frame_count_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = AW + 16;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [10:0]           r_x;
  logic [9:0]            r_y;
  logic [AW-1:0]         r_addr;
  logic [15:0]           r_frame_cnt;
  logic [RENDER_LATENCY-1:0] r_pipe_vld;
  logic [AW-1:0]         r_pipe_addr [RENDER_LATENCY];
  logic [DW-1:0]         r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_inflight;
  logic [CW:0]           w_credit_used;
  logic                  w_issue;
  logic                  w_last;
  logic                  w_push;
  logic                  w_pop;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RENDER_LATENCY; i++) begin
      w_inflight = w_inflight + CW'(r_pipe_vld[i]);
    end
  end

  // Pixels already issued still own a FIFO slot, so a stalled framebuffer can never overflow the skid FIFO.
  assign w_credit_used = {1'b0, r_count} + {1'b0, w_inflight};
  assign w_issue       = (r_state == S_RUN) && (w_credit_used < (CW+1)'(FIFO_DEPTH));
  assign w_last        = (r_x == 11'(WIDTH - 1)) && (r_y == 10'(HEIGHT - 1));
  assign w_push        = r_pipe_vld[RENDER_LATENCY-1];
  assign w_pop         = (r_count != '0) && fb_ready_in;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_in) w_next = S_RUN;
      S_RUN:   if (w_issue && w_last) w_next = S_DRAIN;
      S_DRAIN: if (w_inflight == '0 && r_count == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_addr      <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start_in) begin
        r_x    <= '0;
        r_y    <= '0;
        r_addr <= '0;
      end else if (w_issue) begin
        r_addr <= r_addr + AW'(1);
        if (r_x == 11'(WIDTH - 1)) begin
          r_x <= '0;
          r_y <= (r_y == 10'(HEIGHT - 1)) ? '0 : r_y + 10'd1;
        end else begin
          r_x <= r_x + 11'd1;
        end
      end
      if (r_state == S_DRAIN && w_next == S_DONE) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < RENDER_LATENCY; i++) r_pipe_addr[i] <= '0;
    end else begin
      r_pipe_vld[0]  <= w_issue;
      r_pipe_addr[0] <= r_addr;
      for (int i = 1; i < RENDER_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_addr[i] <= r_pipe_addr[i-1];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {r_pipe_addr[RENDER_LATENCY-1], r_in, g_in, b_in};
        r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign x_out           = r_x;
  assign y_out           = r_y;
  assign {fb_addr_out, fb_data_out} = r_mem[r_rd_ptr];
  assign fb_we_out       = (r_count != '0);
  assign busy_out        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done_out        = (r_state == S_DONE);
  assign frame_count_out = r_frame_cnt;

endmodule
